// File: rtl/lc3_pipe_ctrl.sv
// LC-3 pipeline controller: stage enables, fill, memory stalls, flush, IMEM freeze.
// Optional: define LC3_CTRL_TRAP_HALT_EN to make TRAP (1111) halt the pipeline until reset.
module lc3_pipe_ctrl #(
  parameter int FLUSH_CYCLES = 2,
  parameter int MEM_TIMEOUT  = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        complete_instr,
  input  logic        complete_data,
  input  logic [15:0] IR_Exec,
  input  logic [2:0]  NZP,
  output logic        enable_fetch,
  output logic        enable_updatePC,
  output logic        enable_decode,
  output logic        enable_execute,
  output logic        enable_writeback,
  output logic        br_taken,
  output logic [1:0]  mem_state,
  output logic        mem_err,
  output logic        halted
);

  typedef enum logic [2:0] {S_FILL, S_RUN, S_MEM, S_FLUSH, S_HALT} state_t;
  typedef enum logic [1:0] {K_LD, K_LDI, K_ST, K_STI} kind_t;

  state_t      state_q, state_d;
  kind_t       kind_q, kind_d, mem_kind;
  logic [2:0]  fill_q, fill_d;
  logic [1:0]  flush_q, flush_d;
  logic [1:0]  mst_q, mst_d, mem_first;
  logic [15:0] to_q, to_d;
  logic        store_resume_q, store_resume_d;
  logic        mem_err_q, mem_err_d;

  logic [3:0]  opcode;
  logic        is_mem, xfer_taken, is_trap, timeout_hit, kind_is_store;
  logic        unused_ir;

  assign opcode        = IR_Exec[15:12];
  assign unused_ir     = ^IR_Exec[8:0];
  assign xfer_taken    = ((opcode == 4'b0000) && ((IR_Exec[11:9] & NZP) != 3'b000)) ||
                         (opcode == 4'b1100);
  assign timeout_hit   = (MEM_TIMEOUT > 0) && (to_q == 16'(MEM_TIMEOUT - 1));
  assign kind_is_store = (kind_q == K_ST) || (kind_q == K_STI);
  assign mem_err       = mem_err_q;

`ifdef LC3_CTRL_TRAP_HALT_EN
  assign is_trap = (opcode == 4'b1111);
  assign halted  = (state_q == S_HALT);
`else
  assign is_trap = 1'b0;
  assign halted  = 1'b0;
`endif

  // Access kind and the first mem_state value of its sequence
  always_comb begin
    is_mem    = 1'b1;
    mem_kind  = K_LD;
    mem_first = 2'd0;
    case (opcode)
      4'b0010, 4'b0110: begin mem_kind = K_LD;  mem_first = 2'd0; end
      4'b1010:          begin mem_kind = K_LDI; mem_first = 2'd1; end
      4'b0011, 4'b0111: begin mem_kind = K_ST;  mem_first = 2'd2; end
      4'b1011:          begin mem_kind = K_STI; mem_first = 2'd1; end
      default:          is_mem = 1'b0;
    endcase
  end

  always_comb begin
    enable_fetch     = 1'b0;
    enable_updatePC  = 1'b0;
    enable_decode    = 1'b0;
    enable_execute   = 1'b0;
    enable_writeback = 1'b0;
    br_taken         = 1'b0;
    mem_state        = 2'd3;
    state_d          = state_q;
    kind_d           = kind_q;
    fill_d           = fill_q;
    flush_d          = flush_q;
    mst_d            = mst_q;
    to_d             = to_q;
    store_resume_d   = store_resume_q;
    mem_err_d        = 1'b0;

    case (state_q)
      S_FILL: begin
        // fill_q==0 is the reset cycle itself: everything stays off
        enable_fetch     = (fill_q != 3'd0);
        enable_updatePC  = (fill_q != 3'd0);
        enable_decode    = (fill_q >= 3'd2);
        enable_execute   = (fill_q >= 3'd3);
        enable_writeback = (fill_q >= 3'd4);
        if (fill_q == 3'd4) state_d = S_RUN;
        else                fill_d  = fill_q + 3'd1;
      end
      S_RUN: begin
        enable_fetch     = complete_instr;
        enable_updatePC  = complete_instr;
        enable_decode    = complete_instr;
        enable_execute   = complete_instr;
        enable_writeback = complete_instr & ~store_resume_q;
        if (complete_instr) store_resume_d = 1'b0;
        if (complete_instr && xfer_taken) begin
          br_taken = 1'b1;
          state_d  = S_FLUSH;
          flush_d  = 2'(FLUSH_CYCLES);
        end
      end
      S_FLUSH: begin
        enable_fetch    = complete_instr;
        enable_updatePC = complete_instr;
        enable_decode   = complete_instr && (flush_q == 2'd1);
        if (complete_instr) begin
          if (flush_q == 2'd1) state_d = S_RUN;
          else                 flush_d = flush_q - 2'd1;
        end
      end
      S_MEM: begin
        mem_state = mst_q;
        if (complete_data) begin
          to_d = 16'd0;
          if (mst_q == 2'd1) begin
            mst_d = (kind_q == K_LDI) ? 2'd0 : 2'd2;
          end else begin
            state_d        = S_RUN;
            store_resume_d = kind_is_store;
          end
        end else if (timeout_hit) begin
          // Abandon the access; resume exactly as after a normal completion
          state_d        = S_RUN;
          mem_err_d      = 1'b1;
          store_resume_d = kind_is_store;
        end else begin
          to_d = to_q + 16'd1;
        end
      end
      default: ;
    endcase

    if (((state_q == S_FILL) || (state_q == S_RUN)) && enable_execute) begin
      if (is_mem) begin
        state_d = S_MEM;
        kind_d  = mem_kind;
        mst_d   = mem_first;
        to_d    = 16'd0;
      end else if (is_trap) begin
        state_d = S_HALT;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q        <= S_FILL;
      kind_q         <= K_LD;
      fill_q         <= 3'd0;
      flush_q        <= 2'd0;
      mst_q          <= 2'd3;
      to_q           <= 16'd0;
      store_resume_q <= 1'b0;
      mem_err_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      kind_q         <= kind_d;
      fill_q         <= fill_d;
      flush_q        <= flush_d;
      mst_q          <= mst_d;
      to_q           <= to_d;
      store_resume_q <= store_resume_d;
      mem_err_q      <= mem_err_d;
    end
  end

endmodule

// File: tb/tb_lc3_pipe_ctrl.sv
// Directed self-checking bench for lc3_pipe_ctrl (MEM_TIMEOUT=8, FLUSH_CYCLES=2).
module tb_lc3_pipe_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic        complete_instr, complete_data;
  logic [15:0] IR_Exec;
  logic [2:0]  NZP;
  logic        enable_fetch, enable_updatePC, enable_decode, enable_execute, enable_writeback;
  logic        br_taken, mem_err, halted;
  logic [1:0]  mem_state;
  logic [4:0]  en_v;

  int total  = 0;
  int passed = 0;

  lc3_pipe_ctrl #(.FLUSH_CYCLES(2), .MEM_TIMEOUT(8)) dut (
    .clock(clock), .reset(reset),
    .complete_instr(complete_instr), .complete_data(complete_data),
    .IR_Exec(IR_Exec), .NZP(NZP),
    .enable_fetch(enable_fetch), .enable_updatePC(enable_updatePC),
    .enable_decode(enable_decode), .enable_execute(enable_execute),
    .enable_writeback(enable_writeback), .br_taken(br_taken),
    .mem_state(mem_state), .mem_err(mem_err), .halted(halted)
  );

  always #5 clock = ~clock;
  assign en_v = {enable_fetch, enable_updatePC, enable_decode, enable_execute, enable_writeback};

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got === exp) begin
      passed++;
      $display("check %-14s got=%h exp=%h ok", tag, got, exp);
    end else begin
      $display("FAIL %-14s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Advance one clock, then apply the inputs for the new cycle
  task automatic drive(input logic ci, input logic cd, input logic [15:0] ir, input logic [2:0] nzp);
    @(posedge clock);
    #1;
    complete_instr = ci;
    complete_data  = cd;
    IR_Exec        = ir;
    NZP            = nzp;
    #1;
  endtask

  task automatic fill_seq();
    drive(1, 0, 16'h1000, 3'b000); check("fill1",  16'(en_v), 16'h18);
    drive(1, 0, 16'h1000, 3'b000); check("fill2",  16'(en_v), 16'h1C);
    drive(1, 0, 16'h1000, 3'b000); check("fill3",  16'(en_v), 16'h1E);
    drive(1, 0, 16'h1000, 3'b000); check("fill4",  16'(en_v), 16'h1F);
    drive(1, 0, 16'h1000, 3'b000); check("run",    16'(en_v), 16'h1F);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog time limit expired");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b0; complete_instr = 1'b1; complete_data = 1'b0; IR_Exec = 16'h1000; NZP = 3'b000;
    repeat (3) drive(1, 0, 16'h1000, 3'b000);
    check("rst_en",   16'(en_v),      16'h00);
    check("rst_ms",   16'(mem_state), 16'h3);
    check("rst_err",  16'(mem_err),   16'h0);
    check("rst_halt", 16'(halted),    16'h0);
    check("rst_br",   16'(br_taken),  16'h0);
    reset = 1'b1;
    #1 check("fill0", 16'(en_v), 16'h00);
    fill_seq();

    // LD, three cycles at mem_state 0
    drive(1, 0, 16'h2005, 3'b000); check("ld_issue", 16'(en_v), 16'h1F);
    drive(1, 0, 16'h1000, 3'b000); check("ld_m1_ms", 16'(mem_state), 16'h0); check("ld_m1_en", 16'(en_v), 16'h00);
    drive(1, 0, 16'h1000, 3'b000); check("ld_m2_ms", 16'(mem_state), 16'h0);
    drive(1, 1, 16'h1000, 3'b000); check("ld_m3_ms", 16'(mem_state), 16'h0); check("ld_m3_en", 16'(en_v), 16'h00);
    drive(1, 0, 16'h1000, 3'b000); check("ld_res_en", 16'(en_v), 16'h1F); check("ld_res_ms", 16'(mem_state), 16'h3);

    // LDI: 1 then 0
    drive(1, 0, 16'hA005, 3'b000); check("ldi_issue", 16'(en_v), 16'h1F);
    drive(1, 1, 16'h1000, 3'b000); check("ldi_ms1",  16'(mem_state), 16'h1);
    drive(1, 1, 16'h1000, 3'b000); check("ldi_ms0",  16'(mem_state), 16'h0);
    drive(1, 0, 16'h1000, 3'b000); check("ldi_res",  16'(en_v), 16'h1F); check("ldi_res_ms", 16'(mem_state), 16'h3);

    // Taken BRnzp, then untaken BRn
    drive(1, 0, 16'h0E02, 3'b010); check("br_take",  16'(br_taken), 16'h1); check("br_en", 16'(en_v), 16'h1F);
    drive(1, 0, 16'h1000, 3'b010); check("br_fl1",   16'(en_v), 16'h18); check("br_fl1_bt", 16'(br_taken), 16'h0);
    drive(1, 0, 16'h1000, 3'b010); check("br_fl2",   16'(en_v), 16'h1C);
    drive(1, 0, 16'h1000, 3'b010); check("br_run",   16'(en_v), 16'h1F);
    drive(1, 0, 16'h0802, 3'b010); check("brn_nt",   16'(br_taken), 16'h0);
    drive(1, 0, 16'h1000, 3'b010); check("brn_run",  16'(en_v), 16'h1F);

    // JMP with an IMEM stall inside the flush window
    drive(1, 0, 16'hC1C0, 3'b000); check("jmp_take", 16'(br_taken), 16'h1);
    drive(0, 0, 16'h1000, 3'b000); check("jmp_frz",  16'(en_v), 16'h00);
    drive(1, 0, 16'h1000, 3'b000); check("jmp_fl1",  16'(en_v), 16'h18);
    drive(1, 0, 16'h1000, 3'b000); check("jmp_fl2",  16'(en_v), 16'h1C);
    drive(1, 0, 16'h1000, 3'b000); check("jmp_run",  16'(en_v), 16'h1F);

    // Freeze in RUN hides a memory opcode from detection
    drive(0, 0, 16'h2005, 3'b000); check("frz_en",   16'(en_v), 16'h00);
    drive(1, 0, 16'h1000, 3'b000); check("frz_res",  16'(en_v), 16'h1F); check("frz_ms", 16'(mem_state), 16'h3);

    // ST with no completion: timeout after 8 cycles
    drive(1, 0, 16'h3005, 3'b000); check("st_issue", 16'(en_v), 16'h1F);
    for (int i = 0; i < 8; i++) begin
      drive(1, 0, 16'h1000, 3'b000);
      check($sformatf("st_to_ms%0d", i), 16'(mem_state), 16'h2);
      check($sformatf("st_to_er%0d", i), 16'(mem_err), 16'h0);
    end
    drive(1, 0, 16'h1000, 3'b000);
    check("st_to_err", 16'(mem_err), 16'h1); check("st_to_ms", 16'(mem_state), 16'h3);
    check("st_to_en",  16'(en_v), 16'h1E);
    drive(1, 0, 16'h1000, 3'b000); check("st_err_clr", 16'(mem_err), 16'h0); check("st_run", 16'(en_v), 16'h1F);

    // STI: 1 then 2, store resume without writeback; stray complete_data ignored
    drive(1, 0, 16'hB005, 3'b000); check("sti_issue", 16'(en_v), 16'h1F);
    drive(1, 1, 16'h1000, 3'b000); check("sti_ms1",  16'(mem_state), 16'h1);
    drive(1, 0, 16'h1000, 3'b000); check("sti_ms2a", 16'(mem_state), 16'h2);
    drive(1, 1, 16'h1000, 3'b000); check("sti_ms2b", 16'(mem_state), 16'h2);
    drive(1, 1, 16'h1000, 3'b000); check("sti_res",  16'(en_v), 16'h1E); check("sti_res_ms", 16'(mem_state), 16'h3);
    drive(1, 1, 16'h1000, 3'b000); check("cd_ignore", 16'(mem_state), 16'h3); check("cd_ign_en", 16'(en_v), 16'h1F);

    // TRAP
    drive(1, 0, 16'hF025, 3'b000); check("trap_issue", 16'(en_v), 16'h1F);
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 16'h1000, 3'b000);
`ifdef LC3_CTRL_TRAP_HALT_EN
      check($sformatf("halt_en%0d", i), 16'(en_v), 16'h00);
      check($sformatf("halt_h%0d", i),  16'(halted), 16'h1);
`else
      check($sformatf("trap_en%0d", i), 16'(en_v), 16'h1F);
      check($sformatf("trap_h%0d", i),  16'(halted), 16'h0);
`endif
    end

    reset = 1'b0;
    drive(1, 0, 16'h1000, 3'b000); check("rst2_en", 16'(en_v), 16'h00); check("rst2_halt", 16'(halted), 16'h0);
    reset = 1'b1;
    #1 fill_seq();

    // Reset mid-MEM
    drive(1, 0, 16'h6005, 3'b000); check("ldr_issue", 16'(en_v), 16'h1F);
    drive(1, 0, 16'h1000, 3'b000); check("ldr_ms", 16'(mem_state), 16'h0);
    reset = 1'b0;
    drive(1, 0, 16'h1000, 3'b000); check("rmem_ms", 16'(mem_state), 16'h3); check("rmem_en", 16'(en_v), 16'h00);
    reset = 1'b1;
    #1 fill_seq();

    // Reset mid-FLUSH
    drive(1, 0, 16'hC000, 3'b000); check("jmp2_take", 16'(br_taken), 16'h1);
    drive(1, 0, 16'h1000, 3'b000); check("jmp2_fl1", 16'(en_v), 16'h18);
    reset = 1'b0;
    drive(1, 0, 16'h1000, 3'b000); check("rfl_en", 16'(en_v), 16'h00); check("rfl_br", 16'(br_taken), 16'h0);
    reset = 1'b1;
    #1 fill_seq();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
